apb_bridge_multi: RTL

//  Parametrised APB master bridge: takes single requests from the CPU-side

---
 rtl/apb_bridge_multi.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/apb_bridge_multi.sv
// APB master bridge: one CPU valid/ready request becomes an IDLE/SETUP/ACCESS transfer to a decoded slave.
// Defining APB_TIMEOUT_EN adds a wait-state timeout of TIMEOUT_CYCLES in ACCESS.
module apb_bridge_multi #(
  parameter int ADDR_W         = 5,
  parameter int DATA_W         = 32,
  parameter int NUM_SLAVES     = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                         pclk,
  input  logic                         Reset_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [DATA_W-1:0]            req_wdata,
  output logic                         rsp_valid,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         rsp_err,
  output logic [NUM_SLAVES-1:0]        psel,
  output logic                         penable,
  output logic                         pwrite,
  output logic [ADDR_W-1:0]            paddr,
  output logic [DATA_W-1:0]            pwdata,
  input  logic [NUM_SLAVES-1:0]        pready,
  input  logic [NUM_SLAVES*DATA_W-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]        pslverr
);

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

  state_t                state, state_n;
  logic [SEL_W-1:0]      sel_idx, sel_idx_n, req_idx;
  logic [NUM_SLAVES-1:0] psel_n;
  logic                  penable_n, pwrite_n, rsp_valid_n, rsp_err_n;
  logic [ADDR_W-1:0]     paddr_n;
  logic [DATA_W-1:0]     pwdata_n, rsp_rdata_n, sel_rdata;
  logic                  dec_err, sel_ready, sel_err, timeout_hit;

  assign req_ready = (state == ST_IDLE);

  if (NUM_SLAVES > 1) begin : g_decode
    assign req_idx = req_addr[ADDR_W-1 -: SEL_W];
  end else begin : g_single
    assign req_idx = '0;
  end

  // Index field can encode more slaves than exist when NUM_SLAVES is not a power of two.
  assign dec_err = ({1'b0, req_idx} >= (SEL_W+1)'(NUM_SLAVES));

  // Only the selected slave's response lanes are looked at.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (sel_idx == SEL_W'(k)) begin
        sel_ready = pready[k];
        sel_err   = pslverr[k];
        sel_rdata = prdata[k*DATA_W +: DATA_W];
      end
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;

  // Fires on the ACCESS cycle that would make the low-pready count reach TIMEOUT_CYCLES.
  assign timeout_hit = (state == ST_ACCESS) && !sel_ready &&
                       (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge pclk or negedge Reset_n) begin
    if (!Reset_n)                             tmo_cnt <= '0;
    else if (state == ST_SETUP)               tmo_cnt <= '0;
    else if (state == ST_ACCESS && !sel_ready) tmo_cnt <= tmo_cnt + TMO_W'(1);
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latches).
  always_comb begin
    state_n     = state;
    sel_idx_n   = sel_idx;
    psel_n      = psel;
    penable_n   = penable;
    pwrite_n    = pwrite;
    paddr_n     = paddr;
    pwdata_n    = pwdata;
    rsp_valid_n = 1'b0;
    rsp_err_n   = rsp_err;
    rsp_rdata_n = rsp_rdata;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          pwrite_n  = req_write;
          paddr_n   = req_addr;
          pwdata_n  = req_wdata;
          sel_idx_n = req_idx;
          if (dec_err) begin
            rsp_valid_n = 1'b1;
            rsp_err_n   = 1'b1;
            rsp_rdata_n = '0;
          end else begin
            state_n = ST_SETUP;
            psel_n  = NUM_SLAVES'(1) << req_idx;
          end
        end
      end
      ST_SETUP: begin
        state_n   = ST_ACCESS;
        penable_n = 1'b1;
      end
      ST_ACCESS: begin
        if (sel_ready || timeout_hit) begin
          state_n     = ST_IDLE;
          psel_n      = '0;
          penable_n   = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_err_n   = sel_ready ? sel_err : 1'b1;
          rsp_rdata_n = (!pwrite && !rsp_err_n) ? sel_rdata : '0;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge pclk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= ST_IDLE;
      sel_idx   <= '0;
      psel      <= '0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_n;
      sel_idx   <= sel_idx_n;
      psel      <= psel_n;
      penable   <= penable_n;
      pwrite    <= pwrite_n;
      paddr     <= paddr_n;
      pwdata    <= pwdata_n;
      rsp_valid <= rsp_valid_n;
      rsp_err   <= rsp_err_n;
      rsp_rdata <= rsp_rdata_n;
    end
  end

endmodule
